// File: rtl/axis_dot_param.sv
// axis_dot_param
//   Streaming matrix-vector dot-product engine. One input frame carries an
//   N_IN-element vector followed by an N_OUT x N_IN matrix (row-major). For
//   each matrix row the engine emits one saturated signed dot product; the
//   N_OUT results form one output frame. Frame-length violations (early or
//   missing TLAST) raise a sticky frame_err.
//
// Ports
//   aclk, aresetn          clock (rising edge), asynchronous active-low reset
//   INPUT_AXIS_*           slave stream: TDATA/TLAST/TVALID in, TREADY out
//   OUTPUT_AXIS_*          master stream: TDATA/TLAST/TVALID out, TREADY in
//   frame_err              sticky frame-length violation flag
module axis_dot_param #(
  parameter int N_IN  = 20,
  parameter int N_OUT = 10,
  parameter int DW    = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [DW-1:0] INPUT_AXIS_TDATA,
  input  logic          INPUT_AXIS_TLAST,
  input  logic          INPUT_AXIS_TVALID,
  output logic          INPUT_AXIS_TREADY,
  output logic [DW-1:0] OUTPUT_AXIS_TDATA,
  output logic          OUTPUT_AXIS_TLAST,
  output logic          OUTPUT_AXIS_TVALID,
  input  logic          OUTPUT_AXIS_TREADY,
  output logic          frame_err
);

  localparam int CW = $clog2(N_IN);
  localparam int RW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  // Wide enough that N_IN full-scale products can never overflow.
  localparam int AW = 2 * DW + CW;

  localparam logic [CW-1:0] IDX_LAST = CW'(N_IN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N_OUT - 1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  localparam logic [1:0] S_VEC   = 2'd0;
  localparam logic [1:0] S_ROW   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]           state_reg;
  logic [CW-1:0]        idx_reg;      // vector index in S_VEC, column in S_ROW
  logic [RW-1:0]        row_reg;
  logic signed [AW-1:0] acc_reg;
  logic signed [DW-1:0] vec_reg [N_IN];
  logic [DW-1:0]        out_data_reg;
  logic                 out_last_reg;
  logic                 out_valid_reg;
  logic                 frame_err_reg;

  logic                   in_ready;
  logic                   accept;
  logic                   col_end;
  logic                   row_final;
  logic                   load_out;
  logic signed [2*DW-1:0] product;
  logic signed [AW-1:0]   acc_sum;
  logic [DW-1:0]          sat_val;

  // Ready is forced low while reset is held. In S_ROW the single output
  // register must be empty or draining this cycle before a beat can be taken.
  always_comb begin
    in_ready = 1'b1;
    if (state_reg == S_ROW)
      in_ready = !out_valid_reg || OUTPUT_AXIS_TREADY;
    if (!aresetn)
      in_ready = 1'b0;
  end

  assign accept    = INPUT_AXIS_TVALID && in_ready;
  assign col_end   = (idx_reg == IDX_LAST);
  assign row_final = (row_reg == ROW_LAST);

  assign product = $signed(INPUT_AXIS_TDATA) * vec_reg[idx_reg];
  assign acc_sum = acc_reg + $signed({{(AW-2*DW){product[2*DW-1]}}, product});

  always_comb begin
    sat_val = acc_sum[DW-1:0];
    if (acc_sum > SAT_MAX)
      sat_val = SAT_MAX[DW-1:0];
    else if (acc_sum < SAT_MIN)
      sat_val = SAT_MIN[DW-1:0];
  end

  // A row result is produced at its last column unless TLAST arrived early
  // (TLAST on the final row's last beat is the legitimate end of frame).
  assign load_out = accept && (state_reg == S_ROW) && col_end &&
                    (!INPUT_AXIS_TLAST || row_final);

  // Vector storage: one register per element, written during S_VEC.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_vec
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
          vec_reg[gi] <= '0;
        else if (accept && (state_reg == S_VEC) && !INPUT_AXIS_TLAST &&
                 (idx_reg == CW'(gi)))
          vec_reg[gi] <= $signed(INPUT_AXIS_TDATA);
      end
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= S_VEC;
      idx_reg       <= '0;
      row_reg       <= '0;
      acc_reg       <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_VEC: begin
          if (accept) begin
            if (INPUT_AXIS_TLAST) begin
              frame_err_reg <= 1'b1;
              idx_reg       <= '0;
            end else if (col_end) begin
              state_reg <= S_ROW;
              idx_reg   <= '0;
              row_reg   <= '0;
              acc_reg   <= '0;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        S_ROW: begin
          if (accept) begin
            if (INPUT_AXIS_TLAST && !(col_end && row_final)) begin
              // Early end of frame: drop the partial row, wait for a new vector.
              frame_err_reg <= 1'b1;
              state_reg     <= S_VEC;
              idx_reg       <= '0;
              row_reg       <= '0;
              acc_reg       <= '0;
            end else if (col_end) begin
              acc_reg <= '0;
              idx_reg <= '0;
              if (row_final) begin
                row_reg <= '0;
                if (INPUT_AXIS_TLAST) begin
                  state_reg <= S_VEC;
                end else begin
                  frame_err_reg <= 1'b1;
                  state_reg     <= S_FLUSH;
                end
              end else begin
                row_reg <= row_reg + 1'b1;
              end
            end else begin
              acc_reg <= acc_sum;
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (accept && INPUT_AXIS_TLAST) begin
            state_reg <= S_VEC;
            idx_reg   <= '0;
          end
        end
        default: begin
          state_reg <= S_VEC;
          idx_reg   <= '0;
          row_reg   <= '0;
          acc_reg   <= '0;
        end
      endcase
    end
  end

  // Single output register; data and last hold while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (load_out) begin
      out_data_reg  <= sat_val;
      out_last_reg  <= row_final;
      out_valid_reg <= 1'b1;
    end else if (OUTPUT_AXIS_TREADY) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign INPUT_AXIS_TREADY  = in_ready;
  assign OUTPUT_AXIS_TDATA  = out_data_reg;
  assign OUTPUT_AXIS_TLAST  = out_last_reg;
  assign OUTPUT_AXIS_TVALID = out_valid_reg;
  assign frame_err          = frame_err_reg;

endmodule

// File: tb/tb_axis_dot_param.sv
// tb_axis_dot_param
//   Self-checking bench for axis_dot_param. Main instance uses the default
//   geometry (20x10, 32-bit); a second 16-bit instance with two rows covers
//   output saturation at a narrow width. Expected results come from a
//   wide-integer reference dot product with clamping.
module tb_axis_dot_param;

  localparam int N_IN  = 20;
  localparam int N_OUT = 10;
  localparam int T     = N_IN + N_IN * N_OUT;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] in_data;
  logic        in_last, in_valid, in_ready;
  logic [31:0] out_data;
  logic        out_last, out_valid, out_ready;
  logic        frame_err;

  logic [15:0] s_in_data;
  logic        s_in_last, s_in_valid, s_in_ready;
  logic [15:0] s_out_data;
  logic        s_out_last, s_out_valid, s_out_ready;
  logic        s_frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] vec_a [N_IN];
  logic [31:0] mat_a [N_OUT][N_IN];

  logic [31:0] got_d[$];
  logic        got_l[$];
  int          got_c[$];
  int          acc_c[$];
  logic [15:0] s_got_d[$];
  logic        s_got_l[$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  axis_dot_param #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .INPUT_AXIS_TDATA(in_data), .INPUT_AXIS_TLAST(in_last),
    .INPUT_AXIS_TVALID(in_valid), .INPUT_AXIS_TREADY(in_ready),
    .OUTPUT_AXIS_TDATA(out_data), .OUTPUT_AXIS_TLAST(out_last),
    .OUTPUT_AXIS_TVALID(out_valid), .OUTPUT_AXIS_TREADY(out_ready),
    .frame_err(frame_err)
  );

  axis_dot_param #(.N_IN(N_IN), .N_OUT(2), .DW(16)) dut16 (
    .aclk(aclk), .aresetn(aresetn),
    .INPUT_AXIS_TDATA(s_in_data), .INPUT_AXIS_TLAST(s_in_last),
    .INPUT_AXIS_TVALID(s_in_valid), .INPUT_AXIS_TREADY(s_in_ready),
    .OUTPUT_AXIS_TDATA(s_out_data), .OUTPUT_AXIS_TLAST(s_out_last),
    .OUTPUT_AXIS_TVALID(s_out_valid), .OUTPUT_AXIS_TREADY(s_out_ready),
    .frame_err(s_frame_err)
  );

  // Output monitors: a transfer is seen mid-cycle and completes at the next edge.
  always @(negedge aclk) begin
    #2;
    if (aresetn && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
      got_c.push_back(cyc);
      $display("out[%0d] data=%0d last=%0b", got_d.size() - 1, $signed(out_data), out_last);
    end
    if (aresetn && s_out_valid && s_out_ready) begin
      s_got_d.push_back(s_out_data);
      s_got_l.push_back(s_out_last);
      $display("out16[%0d] data=%0d last=%0b", s_got_d.size() - 1, $signed(s_out_data), s_out_last);
    end
  end

  // Reference: exact dot product in wide arithmetic, then clamp to 32 bits.
  function automatic logic [31:0] ref_dot(input int r);
    logic signed [127:0] s, a, b;
    s = '0;
    for (int c = 0; c < N_IN; c++) begin
      a = $signed(mat_a[r][c]);
      b = $signed(vec_a[c]);
      s = s + a * b;
    end
    if (s > 128'sd2147483647) return 32'h7fffffff;
    if (s < -128'sd2147483648) return 32'h80000000;
    return s[31:0];
  endfunction

  function automatic logic [31:0] beat_data(input int k);
    if (k < N_IN) return vec_a[k];
    return mat_a[(k - N_IN) / N_IN][(k - N_IN) % N_IN];
  endfunction

  task automatic set_default_frame;
    for (int c = 0; c < N_IN; c++) vec_a[c] = 32'd1;
    for (int r = 0; r < N_OUT; r++)
      for (int c = 0; c < N_IN; c++) mat_a[r][c] = r;
  endtask

  task automatic set_random_frame(input bit wide);
    for (int c = 0; c < N_IN; c++)
      vec_a[c] = wide ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
    for (int r = 0; r < N_OUT; r++)
      for (int c = 0; c < N_IN; c++)
        mat_a[r][c] = wide ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
  endtask

  task automatic clear_q;
    got_d.delete(); got_l.delete(); got_c.delete(); acc_c.delete();
  endtask

  task automatic send_beat(input logic [31:0] d, input bit l);
    int guard = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    while (!in_ready && guard < 2000) begin
      @(negedge aclk); #1;
      guard++;
    end
    if (guard >= 2000) begin
      failures++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(negedge aclk); #1;
    acc_c.push_back(cyc);
  endtask

  // Sends the first nbeats of the current frame, TLAST on beat last_at
  // (-1: none), then `extra` junk beats with TLAST on the final one.
  task automatic send_frame(input int nbeats, input int last_at, input int extra);
    for (int k = 0; k < nbeats; k++) send_beat(beat_data(k), k == last_at);
    for (int e = 0; e < extra; e++) send_beat($urandom, e == extra - 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int k = 0;
    while (got_d.size() < n && k < budget) begin
      @(negedge aclk); #3;
      k++;
    end
    checks++;
    if (got_d.size() < n) begin
      failures++;
      $display("FAIL wait_outputs got=%0d required=%0d", got_d.size(), n);
    end
    repeat (6) @(negedge aclk);
    #3;
  endtask

  task automatic do_reset;
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    clear_q();
  endtask

  task automatic test_reset;
    aresetn = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    checks += 6;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b required=0", out_valid); end
    if (out_data !== 32'd0) begin failures++; $display("FAIL reset_tdata got=%h required=0", out_data); end
    if (out_last !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b required=0", out_last); end
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b required=0", frame_err); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b required=0", in_ready); end
    if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_tvalid16 got=%b required=0", s_out_valid); end
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_tready got=%b required=1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_defaults;
    set_default_frame();
    clear_q();
    send_frame(T, T - 1, 0);
    wait_outputs(N_OUT, 500);
    checks++;
    if (got_d.size() !== N_OUT) begin failures++; $display("FAIL dflt_count got=%0d required=%0d", got_d.size(), N_OUT); end
    for (int r = 0; r < N_OUT && r < got_d.size(); r++) begin
      checks += 3;
      if (got_d[r] !== 32'(r * 20)) begin failures++; $display("FAIL dflt_data[%0d] got=%0d required=%0d", r, got_d[r], r * 20); end
      if (got_l[r] !== (r == N_OUT - 1)) begin failures++; $display("FAIL dflt_last[%0d] got=%b required=%b", r, got_l[r], r == N_OUT - 1); end
      if (got_c[r] !== acc_c[N_IN + r * N_IN + N_IN - 1]) begin
        failures++;
        $display("FAIL dflt_latency[%0d] got_cycle=%0d required_cycle=%0d", r, got_c[r], acc_c[N_IN + r * N_IN + N_IN - 1]);
      end
    end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL dflt_frame_err got=%b required=0", frame_err); end
    $display("test_defaults done");
  endtask

  task automatic test_backpressure;
    set_default_frame();
    clear_q();
    fork
      send_frame(T, T - 1, 0);
      begin
        int guard = 0;
        forever begin
          @(negedge aclk);
          guard++;
          if ((out_valid && got_d.size() == 3) || guard > 1000) break;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          #2;
          checks += 4;
          if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b required=1", i, out_valid); end
          if (out_data !== 32'd60) begin failures++; $display("FAIL bp_hold[%0d] got=%0d required=60", i, out_data); end
          if (out_last !== 1'b0) begin failures++; $display("FAIL bp_last[%0d] got=%b required=0", i, out_last); end
          if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_tready[%0d] got=%b required=0", i, in_ready); end
          @(negedge aclk);
        end
        out_ready = 1'b1;
      end
    join
    wait_outputs(N_OUT, 500);
    checks++;
    if (got_d.size() !== N_OUT) begin failures++; $display("FAIL bp_count got=%0d required=%0d", got_d.size(), N_OUT); end
    for (int r = 0; r < N_OUT && r < got_d.size(); r++) begin
      checks += 2;
      if (got_d[r] !== 32'(r * 20)) begin failures++; $display("FAIL bp_data[%0d] got=%0d required=%0d", r, got_d[r], r * 20); end
      if (got_l[r] !== (r == N_OUT - 1)) begin failures++; $display("FAIL bp_last_seq[%0d] got=%b required=%b", r, got_l[r], r == N_OUT - 1); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_random;
    for (int f = 0; f < 4; f++) begin
      bit done = 1'b0;
      set_random_frame(f[0]);
      clear_q();
      fork
        begin
          send_frame(T, T - 1, 0);
          wait_outputs(N_OUT, 3000);
          done = 1'b1;
        end
        while (!done) begin
          @(negedge aclk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      join
      out_ready = 1'b1;
      checks++;
      if (got_d.size() !== N_OUT) begin failures++; $display("FAIL rnd%0d_count got=%0d required=%0d", f, got_d.size(), N_OUT); end
      for (int r = 0; r < N_OUT && r < got_d.size(); r++) begin
        checks += 2;
        if (got_d[r] !== ref_dot(r)) begin failures++; $display("FAIL rnd%0d_data[%0d] got=%h required=%h", f, r, got_d[r], ref_dot(r)); end
        if (got_l[r] !== (r == N_OUT - 1)) begin failures++; $display("FAIL rnd%0d_last[%0d] got=%b required=%b", f, r, got_l[r], r == N_OUT - 1); end
      end
      $display("test_random frame %0d done", f);
    end
  endtask

  // Follow-up frame after an error: full 0..180 sequence, frame_err stays set.
  task automatic check_recovery(input string tag);
    set_default_frame();
    clear_q();
    send_frame(T, T - 1, 0);
    wait_outputs(N_OUT, 500);
    checks += 2;
    if (got_d.size() !== N_OUT) begin failures++; $display("FAIL %s_rec_count got=%0d required=%0d", tag, got_d.size(), N_OUT); end
    if (frame_err !== 1'b1) begin failures++; $display("FAIL %s_sticky got=%b required=1", tag, frame_err); end
    for (int r = 0; r < N_OUT && r < got_d.size(); r++) begin
      checks += 2;
      if (got_d[r] !== 32'(r * 20)) begin failures++; $display("FAIL %s_rec_data[%0d] got=%0d required=%0d", tag, r, got_d[r], r * 20); end
      if (got_l[r] !== (r == N_OUT - 1)) begin failures++; $display("FAIL %s_rec_last[%0d] got=%b required=%b", tag, r, got_l[r], r == N_OUT - 1); end
    end
  endtask

  task automatic test_early_last;
    do_reset();
    set_default_frame();
    send_frame(N_IN + 46, N_IN + 45, 0);
    repeat (20) @(negedge aclk);
    #3;
    checks += 2;
    if (got_d.size() !== 2) begin failures++; $display("FAIL early_count got=%0d required=2", got_d.size()); end
    if (frame_err !== 1'b1) begin failures++; $display("FAIL early_frame_err got=%b required=1", frame_err); end
    for (int r = 0; r < 2 && r < got_d.size(); r++) begin
      checks += 2;
      if (got_d[r] !== 32'(r * 20)) begin failures++; $display("FAIL early_data[%0d] got=%0d required=%0d", r, got_d[r], r * 20); end
      if (got_l[r] !== 1'b0) begin failures++; $display("FAIL early_last[%0d] got=%b required=0", r, got_l[r]); end
    end
    check_recovery("early");
    $display("test_early_last done");
  endtask

  task automatic test_missing_last;
    do_reset();
    set_default_frame();
    send_frame(T, -1, 3);
    wait_outputs(N_OUT, 500);
    checks += 2;
    if (got_d.size() !== N_OUT) begin failures++; $display("FAIL miss_count got=%0d required=%0d", got_d.size(), N_OUT); end
    if (frame_err !== 1'b1) begin failures++; $display("FAIL miss_frame_err got=%b required=1", frame_err); end
    for (int r = 0; r < N_OUT && r < got_d.size(); r++) begin
      checks++;
      if (got_d[r] !== 32'(r * 20)) begin failures++; $display("FAIL miss_data[%0d] got=%0d required=%0d", r, got_d[r], r * 20); end
    end
    check_recovery("miss");
    $display("test_missing_last done");
  endtask

  task automatic test_vec_last;
    do_reset();
    set_default_frame();
    send_frame(5, 4, 0);
    repeat (5) @(negedge aclk);
    #3;
    checks += 2;
    if (frame_err !== 1'b1) begin failures++; $display("FAIL veclast_frame_err got=%b required=1", frame_err); end
    if (got_d.size() !== 0) begin failures++; $display("FAIL veclast_count got=%0d required=0", got_d.size()); end
    check_recovery("veclast");
    $display("test_vec_last done");
  endtask

  task automatic test_midreset;
    do_reset();
    set_default_frame();
    send_frame(N_IN + 4 * N_IN + 7, -1, 0);
    aresetn = 1'b0;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_tvalid got=%b required=0", out_valid); end
    if (out_data !== 32'd0) begin failures++; $display("FAIL mid_tdata got=%0d required=0", out_data); end
    if (out_last !== 1'b0) begin failures++; $display("FAIL mid_tlast got=%b required=0", out_last); end
    if (frame_err !== 1'b0) begin failures++; $display("FAIL mid_frame_err got=%b required=0", frame_err); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_tready got=%b required=0", in_ready); end
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    set_default_frame();
    clear_q();
    send_frame(T, T - 1, 0);
    wait_outputs(N_OUT, 500);
    checks += 2;
    if (got_d.size() !== N_OUT) begin failures++; $display("FAIL mid_rec_count got=%0d required=%0d", got_d.size(), N_OUT); end
    if (frame_err !== 1'b0) begin failures++; $display("FAIL mid_rec_frame_err got=%b required=0", frame_err); end
    for (int r = 0; r < N_OUT && r < got_d.size(); r++) begin
      checks++;
      if (got_d[r] !== 32'(r * 20)) begin failures++; $display("FAIL mid_rec_data[%0d] got=%0d required=%0d", r, got_d[r], r * 20); end
    end
    $display("test_midreset done");
  endtask

  task automatic test_sat16;
    int guard;
    s_got_d.delete(); s_got_l.delete();
    s_out_ready = 1'b1;
    for (int k = 0; k < 3 * N_IN; k++) begin
      s_in_valid = 1'b1;
      s_in_data  = (k < 2 * N_IN) ? 16'h7fff : 16'h8000;
      s_in_last  = (k == 3 * N_IN - 1);
      guard = 0;
      while (!s_in_ready && guard < 200) begin @(negedge aclk); #1; guard++; end
      @(negedge aclk); #1;
    end
    s_in_valid = 1'b0; s_in_last = 1'b0;
    guard = 0;
    while (s_got_d.size() < 2 && guard < 100) begin @(negedge aclk); #3; guard++; end
    checks += 2;
    if (s_got_d.size() !== 2) begin failures++; $display("FAIL sat16_count got=%0d required=2", s_got_d.size()); end
    if (s_frame_err !== 1'b0) begin failures++; $display("FAIL sat16_frame_err got=%b required=0", s_frame_err); end
    if (s_got_d.size() == 2) begin
      checks += 4;
      if (s_got_d[0] !== 16'h7fff) begin failures++; $display("FAIL sat16_pos got=%h required=7fff", s_got_d[0]); end
      if (s_got_d[1] !== 16'h8000) begin failures++; $display("FAIL sat16_neg got=%h required=8000", s_got_d[1]); end
      if (s_got_l[0] !== 1'b0) begin failures++; $display("FAIL sat16_last0 got=%b required=0", s_got_l[0]); end
      if (s_got_l[1] !== 1'b1) begin failures++; $display("FAIL sat16_last1 got=%b required=1", s_got_l[1]); end
    end
    $display("test_sat16 done");
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_backpressure();
    test_random();
    test_early_last();
    test_missing_last();
    test_vec_last();
    test_midreset();
    test_sat16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
